// File: rtl/adc_max10_avg_filter.sv
// Per-channel averaging filter for the MAX10 modular ADC response stream, with a latest-result register file.
// Define ADC_AVG_ROUND_EN to round averages half-up instead of truncating.
module adc_max10_avg_filter #(
   parameter int NUM_CH   = 17,
   parameter int AVG_LOG2 = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [4:0]  in_channel,
   input  logic [11:0] in_data,
   output logic        out_valid,
   output logic [4:0]  out_channel,
   output logic [11:0] out_data,
   input  logic [4:0]  rd_channel,
   output logic [11:0] rd_data,
   output logic        rd_fresh,
   input  logic        rd_ack,
   output logic        err_chan
);

   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [5:0] NUM_CH_W = 6'(NUM_CH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ACC_W-1:0] HALF = ACC_W'((AVG_LOG2 > 0) ? (1 << (AVG_LOG2 - 1)) : 0);

   logic [ACC_W-1:0]  acc [NUM_CH];
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [11:0]       res [NUM_CH];
   logic [NUM_CH-1:0] fresh;

   logic              in_range;
   logic              rd_range;
   logic [4:0]        ch_idx;
   logic [4:0]        rd_idx;
   logic              terminal;
   logic [ACC_W-1:0]  sum;
   logic [ACC_W-1:0]  biased;
   logic [11:0]       avg;

   assign in_range = ({1'b0, in_channel} < NUM_CH_W);
   assign rd_range = ({1'b0, rd_channel} < NUM_CH_W);
   assign ch_idx   = in_range ? in_channel : 5'd0;
   assign rd_idx   = rd_range ? rd_channel : 5'd0;

   // With AVG_LOG2=0 every sample is terminal, so the counter is never consulted.
   assign terminal = (AVG_LOG2 == 0) || (cnt[ch_idx] == CNT_MAX);
   assign sum      = acc[ch_idx] + ACC_W'(in_data);

`ifdef ADC_AVG_ROUND_EN
   assign biased = sum + HALF;
`else
   assign biased = sum;
`endif

   assign avg = 12'(biased >> AVG_LOG2);

   assign rd_data  = rd_range ? res[rd_idx] : 12'd0;
   assign rd_fresh = rd_range ? fresh[rd_idx] : 1'b0;

   // Reset wipes everything; clear flushes accumulation state but keeps the last results.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
            res[i] <= '0;
         end
         fresh       <= '0;
         err_chan    <= 1'b0;
         out_valid   <= 1'b0;
         out_channel <= 5'd0;
         out_data    <= 12'd0;
      end else if (clear) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
         fresh     <= '0;
         err_chan  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (rd_ack && rd_range) begin
            fresh[rd_idx] <= 1'b0;
         end
         // A completing average is written after the ack so that set wins on the same channel.
         if (in_valid) begin
            if (!in_range) begin
               err_chan <= 1'b1;
            end else if (!terminal) begin
               acc[ch_idx] <= sum;
               cnt[ch_idx] <= cnt[ch_idx] + CNT_W'(1);
            end else begin
               acc[ch_idx]   <= '0;
               cnt[ch_idx]   <= '0;
               res[ch_idx]   <= avg;
               fresh[ch_idx] <= 1'b1;
               out_valid     <= 1'b1;
               out_channel   <= in_channel;
               out_data      <= avg;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_max10_avg_filter.sv
// Self-checking bench for adc_max10_avg_filter: directed scenarios plus a randomized run
// compared against a queue-based averaging model.
module tb_adc_max10_avg_filter;

   localparam int NUM_CH   = 17;
   localparam int AVG_LOG2 = 3;
   localparam int N        = 1 << AVG_LOG2;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic [4:0]  in_channel;
   logic [11:0] in_data;
   logic        out_valid;
   logic [4:0]  out_channel;
   logic [11:0] out_data;
   logic [4:0]  rd_channel;
   logic [11:0] rd_data;
   logic        rd_fresh;
   logic        rd_ack;
   logic        err_chan;

   int total;
   int bad;

   // Reference model: raw samples per channel, averaged when N have been collected.
   int q [NUM_CH][$];
   int m_res [NUM_CH];
   bit m_fresh [NUM_CH];
   bit m_err;
   bit exp_valid;
   int exp_ch;
   int exp_data;

   adc_max10_avg_filter #(.NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2)) dut (
      .CLK(clk),
      .RESET(reset),
      .clear(clear),
      .in_valid(in_valid),
      .in_channel(in_channel),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_channel(out_channel),
      .out_data(out_data),
      .rd_channel(rd_channel),
      .rd_data(rd_data),
      .rd_fresh(rd_fresh),
      .rd_ack(rd_ack),
      .err_chan(err_chan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int average(int s);
      int half;
      half = 0;
`ifdef ADC_AVG_ROUND_EN
      if (AVG_LOG2 > 0) half = N / 2;
`endif
      return (s + half) / N;
   endfunction

   function automatic int exp_rd_data(int c);
      return (c < NUM_CH) ? m_res[c] : 0;
   endfunction

   function automatic int exp_rd_fresh(int c);
      return (c < NUM_CH) ? int'(m_fresh[c]) : 0;
   endfunction

   // Advance one clock with the currently driven inputs, updating the model alongside.
   task automatic step();
      int ch;
      int s;
      exp_valid = 1'b0;
      ch = int'(in_channel);
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            m_res[c] = 0;
            m_fresh[c] = 1'b0;
         end
         m_err = 1'b0;
         exp_ch = 0;
         exp_data = 0;
      end else if (clear) begin
         for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            m_fresh[c] = 1'b0;
         end
         m_err = 1'b0;
      end else begin
         if (rd_ack && int'(rd_channel) < NUM_CH) m_fresh[rd_channel] = 1'b0;
         if (in_valid) begin
            if (ch >= NUM_CH) begin
               m_err = 1'b1;
            end else begin
               q[ch].push_back(int'(in_data));
               if (q[ch].size() == N) begin
                  s = 0;
                  foreach (q[ch][k]) s += q[ch][k];
                  exp_valid = 1'b1;
                  exp_ch = ch;
                  exp_data = average(s);
                  m_res[ch] = exp_data;
                  m_fresh[ch] = 1'b1;
                  q[ch].delete();
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyIdle();
      reset = 1'b0;
      clear = 1'b0;
      in_valid = 1'b0;
      in_channel = 5'd0;
      in_data = 12'd0;
      rd_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1;
      in_channel = 5'd3;
      in_data = 12'd500;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out_valid cyc%0d: got %b want 0", i, out_valid);
         end
      end
      applyIdle();
      step();
      total++;
      if (out_valid !== 1'b0 || out_data !== 12'd0 || out_channel !== 5'd0 || err_chan !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got v=%b ch=%0d d=%0d err=%b want 0 0 0 0",
                  out_valid, out_channel, out_data, err_chan);
      end
      for (int c = 0; c < 32; c++) begin
         rd_channel = 5'(c);
         #1;
         total++;
         if (rd_data !== 12'd0 || rd_fresh !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_regfile ch%0d: got d=%0d f=%b want 0 0", c, rd_data, rd_fresh);
         end
      end
   endtask

   task automatic test_single_channel();
      int want;
      int pulses;
      want = 103;
`ifdef ADC_AVG_ROUND_EN
      want = 104;
`endif
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_channel = 5'd3;
         in_data = 12'(100 + i);
         step();
         if (out_valid === 1'b1) pulses++;
         total++;
         if (out_valid !== exp_valid) begin
            bad++;
            $display("[TB] FAIL single_valid s%0d: got %b want %b", i, out_valid, exp_valid);
         end
      end
      total++;
      if (pulses != 1 || out_channel !== 5'd3 || int'(out_data) != want) begin
         bad++;
         $display("[TB] FAIL single_result: got pulses=%0d ch=%0d d=%0d want 1 3 %0d",
                  pulses, out_channel, out_data, want);
      end
      applyIdle();
      step();
      total++;
      if (out_valid !== 1'b0 || int'(out_data) != want) begin
         bad++;
         $display("[TB] FAIL single_hold: got v=%b d=%0d want 0 %0d", out_valid, out_data, want);
      end
      rd_channel = 5'd3;
      #1;
      total++;
      if (int'(rd_data) != want || rd_fresh !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_regfile: got d=%0d f=%b want %0d 1", rd_data, rd_fresh, want);
      end
   endtask

   task automatic test_back_to_back();
      int seen_ch [$];
      int seen_d [$];
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_channel = (i % 2 == 0) ? 5'd1 : 5'd16;
         in_data = (i % 2 == 0) ? 12'd4095 : 12'd0;
         step();
         total++;
         if (out_valid !== exp_valid) begin
            bad++;
            $display("[TB] FAIL b2b_valid s%0d: got %b want %b", i, out_valid, exp_valid);
         end
         if (out_valid === 1'b1) begin
            seen_ch.push_back(int'(out_channel));
            seen_d.push_back(int'(out_data));
         end
      end
      applyIdle();
      total++;
      if (seen_ch.size() != 2) begin
         bad++;
         $display("[TB] FAIL b2b_pulses: got %0d want 2", seen_ch.size());
      end else if (seen_ch[0] != 1 || seen_d[0] != 4095 || seen_ch[1] != 16 || seen_d[1] != 0) begin
         bad++;
         $display("[TB] FAIL b2b_order: got ch%0d=%0d ch%0d=%0d want ch1=4095 ch16=0",
                  seen_ch[0], seen_d[0], seen_ch[1], seen_d[1]);
      end
   endtask

   task automatic test_clear_midway();
      rd_channel = 5'd2;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_channel = 5'd2;
         in_data = 12'd40;
         step();
      end
      for (int i = 0; i < 5; i++) begin
         in_data = 12'd200;
         step();
      end
      clear = 1'b1;
      in_data = 12'd999;
      step();
      clear = 1'b0;
      total++;
      if (rd_data !== 12'd40 || out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL clear_keeps_res: got d=%0d v=%b want 40 0", rd_data, out_valid);
      end
      for (int i = 0; i < 8; i++) begin
         in_data = 12'd10;
         step();
         total++;
         if (out_valid !== exp_valid || int'(rd_data) != exp_rd_data(2)) begin
            bad++;
            $display("[TB] FAIL clear_refill s%0d: got v=%b rd=%0d want %b %0d",
                     i, out_valid, rd_data, exp_valid, exp_rd_data(2));
         end
      end
      total++;
      if (out_data !== 12'd10 || rd_data !== 12'd10) begin
         bad++;
         $display("[TB] FAIL clear_result: got d=%0d rd=%0d want 10 10", out_data, rd_data);
      end
      applyIdle();
   endtask

   task automatic test_out_of_range();
      in_valid = 1'b1;
      in_channel = 5'd20;
      in_data = 12'd77;
      step();
      total++;
      if (out_valid !== 1'b0 || err_chan !== 1'b1) begin
         bad++;
         $display("[TB] FAIL oor_sample: got v=%b err=%b want 0 1", out_valid, err_chan);
      end
      applyIdle();
      for (int i = 0; i < 3; i++) step();
      total++;
      if (err_chan !== 1'b1) begin
         bad++;
         $display("[TB] FAIL oor_sticky: got %b want 1", err_chan);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      total++;
      if (err_chan !== 1'b0) begin
         bad++;
         $display("[TB] FAIL oor_clear: got %b want 0", err_chan);
      end
   endtask

   task automatic test_ack_collision();
      rd_channel = 5'd3;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_channel = 5'd3;
         in_data = 12'(i * 50);
         rd_ack = (i == 7);
         step();
      end
      applyIdle();
      total++;
      if (rd_fresh !== 1'b1 || out_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ack_set_wins: got f=%b v=%b want 1 1", rd_fresh, out_valid);
      end
      rd_channel = 5'd25;
      rd_ack = 1'b1;
      step();
      rd_channel = 5'd3;
      rd_ack = 1'b0;
      #1;
      total++;
      if (rd_fresh !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ack_oor_ignored: got %b want 1", rd_fresh);
      end
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      total++;
      if (rd_fresh !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ack_clears: got %b want 0", rd_fresh);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_channel = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(17, 31))
                                                    : 5'($urandom_range(0, 4));
         in_data = 12'($urandom);
         rd_channel = 5'($urandom_range(0, 31));
         rd_ack = ($urandom_range(0, 5) == 0);
         clear = ($urandom_range(0, 99) == 0);
         step();
         total++;
         if (out_valid !== exp_valid || int'(out_channel) != exp_ch || int'(out_data) != exp_data ||
             err_chan !== m_err || int'(rd_data) != exp_rd_data(int'(rd_channel)) ||
             int'(rd_fresh) != exp_rd_fresh(int'(rd_channel))) begin
            bad++;
            $display("[TB] FAIL random c%0d: got v=%b ch=%0d d=%0d err=%b rd=%0d f=%b want %b %0d %0d %b %0d %0d",
                     i, out_valid, out_channel, out_data, err_chan, rd_data, rd_fresh,
                     exp_valid, exp_ch, exp_data, m_err, exp_rd_data(int'(rd_channel)),
                     exp_rd_fresh(int'(rd_channel)));
         end
      end
      applyIdle();
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_valid = 1'b0;
      exp_ch = 0;
      exp_data = 0;
      m_err = 1'b0;
      applyIdle();
      rd_channel = 5'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_channel();
      test_back_to_back();
      test_clear_midway();
      test_out_of_range();
      test_ack_collision();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
